pwm_to_axis: RTL
================

Name: pwm_to_axis

Overview:
- Measures the duty cycle of G_NUM_CHANNELS PWM inputs over a fixed measurement window.
- Reports each channel's high-cycle count as an AXI4-Stream beat, using the same 24-bit {channel, duty} word format that the PWM generator side consumes.
- Sits on the capture/monitor side of the PWM subsystem, either in loopback test of the generator or for measuring external PWM sources, and feeds a stream master such as a DMA or UART bridge.

Parameters:
- G_NUM_CHANNELS, 4, number of PWM inputs; legal range 1..16 because the channel field is 4 bits.
- G_PWM_PERIOD_CYCLES, 1000, measurement window length in clk cycles; must be at least G_NUM_CHANNELS + 2.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  reset, synchronous and active-high.
- pwm_in  in  G_NUM_CHANNELS  asynchronous PWM inputs.
- axis_out_tvalid  out  1  stream beat valid.
- axis_out_tdata  out  24  [23:20]=0, [19:16]=channel index, [15:0]=high-cycle count.
- axis_out_tready  in  1  downstream ready.
- overrun  out  G_NUM_CHANNELS  sticky per channel: a result was overwritten before it was sent.

Behaviour:
- Reset values (clk, rst=1): axis_out_tvalid=0, axis_out_tdata=0, overrun=0, all pending=0, all counters=0, window counter=0, round-robin pointer=0.
- Synchronizer: each pwm_in bit passes through 2 flops; s[i] is the synchronized sample. Input-to-count latency is 2 cycles.
- Window counter: win runs 0..G_PWM_PERIOD_CYCLES-1 and wraps. win_end = (win == P-1).
- Channel counter: cnt[i] increments each cycle s[i]=1 and saturates at 16'hFFFF.
- On win_end:
  - result[i] <= sat(cnt[i] + s[i]).
  - cnt[i] <= 0.
  - pending[i] <= 1.
  - Therefore 100% high yields min(P, 65535) and 0% yields 0.
- Overrun: on win_end, if pending[i]=1 and channel i is not being loaded into the output register that same cycle, set overrun[i]. overrun clears only on rst. The new result overwrites the old one.
- Output register, single stage:
  - A slot is free when tvalid=0, or when tvalid && tready (the beat is consumed this cycle).
  - When the slot is free and any pending bit is set, select the first pending channel at or after rr_ptr, wrapping modulo N.
  - On that selection: load tdata = {4'b0, ch, result[ch]}, set tvalid=1, clear pending[ch], set rr_ptr = ch+1 mod N.
  - Result-to-tvalid latency is 1 cycle after pending is set.
- Simultaneous load and win_end on the same channel: the old result goes into tdata, the new result is latched into result, and pending stays 1. No overrun is flagged.
- tvalid && tready with nothing pending: tvalid drops to 0 on the next cycle.
- AXIS rules:
  - While tvalid=1 and tready=0, tdata and tvalid are held stable.
  - tvalid never depends combinationally on tready.
  - tready has no effect when tvalid=0.
- Reset mid-transfer: tvalid=0 on the cycle after rst is sampled high. Pending data is discarded and the current window restarts from 0.
- Bandwidth: at most 1 beat per cycle, so N beats per window are sustainable when tready=1.

Decomposition:
- Package pwm_axis_pkg holds:
  - localparams for the tdata layout (CH_MSB=19, CH_LSB=16, DUTY_MSB=15, DUTY_LSB=0).
  - DUTY_W=16, CH_W=4, DUTY_MAX=16'hFFFF.
  - A packed struct typedef for the 24-bit word.
- Sub-module pwm_meas_channel covers one channel: 2-flop synchronizer, saturating counter, and result register. It has inputs clk, rst, pwm_in, win_end and output result[15:0]. It is instantiated in a generate loop.
- The top level holds the window counter, pending/overrun logic, round-robin arbiter and output register.

Test Plan (N=4, P=100 unless stated):
- pwm_in[0] held at 1, tready=1 → from the second window on, beat tdata=24'h000064 each window; channel 1 held at 0 → tdata=24'h010000.
- Channel 2 at 25% duty (25 high / 75 low, free-running, any phase) → tdata=24'h020019 every window; overrun stays 0.
- All 4 channels active, tready=1 → after each win_end, 4 consecutive beats in order ch0, ch1, ch2, ch3; the next window's burst again starts at rr_ptr.
- tready=0 for 3 windows → tvalid stays 1 with tdata unchanged throughout; overrun becomes 4'b1111 (channels 1-3 at the 2nd win_end, channel 0 at the 3rd); after tready=1, beats carry the latest window values.
- rst asserted for 1 cycle while tvalid=1 and tready=0 → next cycle tvalid=0, tdata=0, overrun=0; the first new beat appears P+1 cycles after rst deasserts.
- P=70000, pwm_in[3]=1 → tdata[15:0]=16'hFFFF (saturation), with no wrap to a small value.

Source files
------------

// File: rtl/pwm_axis_pkg.sv
// Shared constants and stream word layout for the PWM capture side.
// The 24-bit word matches the {channel, duty} format the PWM generator consumes.
package pwm_axis_pkg;

   localparam int CH_MSB   = 19;
   localparam int CH_LSB   = 16;
   localparam int DUTY_MSB = 15;
   localparam int DUTY_LSB = 0;
   localparam int DUTY_W   = 16;
   localparam int CH_W     = 4;
   localparam logic [DUTY_W-1:0] DUTY_MAX = 16'hFFFF;

   typedef struct packed {
      logic [3:0]        rsvd;
      logic [CH_W-1:0]   ch;
      logic [DUTY_W-1:0] duty;
   } axis_word_t;

   // Increment that sticks at DUTY_MAX instead of wrapping.
   function automatic logic [DUTY_W-1:0] sat_inc(input logic [DUTY_W-1:0] v,
                                                  input logic inc);
      return (inc && (v != DUTY_MAX)) ? v + 16'd1 : v;
   endfunction

endpackage

// File: rtl/pwm_meas_channel.sv
// One PWM capture lane: 2-flop synchronizer, saturating high-cycle counter and
// a result register that snapshots the count at each window end.
module pwm_meas_channel
   import pwm_axis_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   input  logic              win_end,
   output logic [DUTY_W-1:0] result
);

   logic              sync_q1;
   logic              s;
   logic [DUTY_W-1:0] cnt;

   // The last sample of the window is folded into the result directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         s       <= 1'b0;
         cnt     <= '0;
         result  <= '0;
      end else begin
         sync_q1 <= pwm_in;
         s       <= sync_q1;
         if (win_end) begin
            result <= sat_inc(cnt, s);
            cnt    <= '0;
         end else begin
            cnt <= sat_inc(cnt, s);
         end
      end
   end

endmodule

// File: rtl/pwm_to_axis.sv
// Multi-channel PWM duty meter: counts high cycles per fixed window and
// streams one {channel, duty} AXI4-Stream beat per channel per window.
module pwm_to_axis
   import pwm_axis_pkg::*;
#(
   parameter int G_NUM_CHANNELS      = 4,
   parameter int G_PWM_PERIOD_CYCLES = 1000
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [G_NUM_CHANNELS-1:0] pwm_in,
   output logic                      axis_out_tvalid,
   output logic [23:0]               axis_out_tdata,
   input  logic                      axis_out_tready,
   output logic [G_NUM_CHANNELS-1:0] overrun
);

   localparam int N     = G_NUM_CHANNELS;
   localparam int P     = G_PWM_PERIOD_CYCLES;
   localparam int WIN_W = (P > 1) ? $clog2(P) : 1;

   logic [WIN_W-1:0]  win;
   logic              win_end;
   logic [DUTY_W-1:0] result [N];
   logic [N-1:0]      pending;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   sel_ch;
   logic              sel_valid;
   logic              slot_free;
   logic              load;
   axis_word_t        word;

   assign win_end = (win == WIN_W'(P - 1));

   always_ff @(posedge clk) begin
      if (rst)          win <= '0;
      else if (win_end) win <= '0;
      else              win <= win + 1'b1;
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_ch
      pwm_meas_channel u_ch (
         .clk     (clk),
         .rst     (rst),
         .pwm_in  (pwm_in[gi]),
         .win_end (win_end),
         .result  (result[gi])
      );
   end

   // Round-robin pick: scan downward so the nearest pending channel at or after
   // rr_ptr is the one left standing.
   always_comb begin
      sel_valid = 1'b0;
      sel_ch    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (pending[(int'(rr_ptr) + k) % N]) begin
            sel_valid = 1'b1;
            sel_ch    = CH_W'((int'(rr_ptr) + k) % N);
         end
      end
   end

   // Stream handshake: a beat transfers on any clk edge with tvalid && tready.
   // tvalid/tdata come only from registers, never combinationally from tready,
   // and stay frozen while tvalid=1 and tready=0. The slot refills in the same
   // cycle a beat is consumed, so back-to-back beats run at full rate.
   assign slot_free = !axis_out_tvalid || axis_out_tready;
   assign load      = slot_free && sel_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         axis_out_tvalid <= 1'b0;
         word            <= '0;
         rr_ptr          <= '0;
      end else if (load) begin
         axis_out_tvalid <= 1'b1;
         word.rsvd       <= '0;
         word.ch         <= sel_ch;
         word.duty       <= result[sel_ch];
         rr_ptr          <= (sel_ch == CH_W'(N - 1)) ? '0 : sel_ch + 1'b1;
      end else if (axis_out_tready) begin
         axis_out_tvalid <= 1'b0;
      end
   end

   // A window end on the channel being loaded keeps pending set for the fresh
   // result; only an unsent result being replaced counts as an overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         overrun <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (win_end) begin
               pending[i] <= 1'b1;
               if (pending[i] && !(load && (sel_ch == CH_W'(i))))
                  overrun[i] <= 1'b1;
            end else if (load && (sel_ch == CH_W'(i))) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   assign axis_out_tdata = word;

endmodule
